// File: rtl/immgen_pkg.sv
// Immediate-format encodings and the single combinational immediate decoder.
// imm_decode returns {err, imm[63:0]}; callers keep the low XLEN bits.
package immgen_pkg;

   localparam logic [3:0] IMMSRC_I     = 4'd0;
   localparam logic [3:0] IMMSRC_S     = 4'd1;
   localparam logic [3:0] IMMSRC_B     = 4'd2;
   localparam logic [3:0] IMMSRC_J     = 4'd3;
   localparam logic [3:0] IMMSRC_U     = 4'd4;
   localparam logic [3:0] IMMSRC_Z     = 4'd5;
   localparam logic [3:0] IMMSRC_SHAMT = 4'd6;
   localparam logic [3:0] IMMSRC_CI    = 4'd7;
   localparam logic [3:0] IMMSRC_CJ    = 4'd8;
   localparam logic [3:0] IMMSRC_CB    = 4'd9;

   function automatic logic [64:0] imm_decode(input logic [31:0] instr,
                                              input logic [3:0]  immsrc,
                                              input logic        xlen64,
                                              input logic        rvc);
      logic [63:0] imm;
      logic        err;
      imm = '0;
      err = 1'b0;
      case (immsrc)
         IMMSRC_I:     imm = {{52{instr[31]}}, instr[31:20]};
         IMMSRC_S:     imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
         IMMSRC_B:     imm = {{51{instr[31]}}, instr[31], instr[7], instr[30:25],
                              instr[11:8], 1'b0};
         IMMSRC_J:     imm = {{43{instr[31]}}, instr[31], instr[19:12], instr[20],
                              instr[30:21], 1'b0};
         IMMSRC_U:     imm = {{32{instr[31]}}, instr[31:12], 12'b0};
         IMMSRC_Z:     imm = {59'b0, instr[19:15]};
         IMMSRC_SHAMT: imm = xlen64 ? {58'b0, instr[25:20]} : {59'b0, instr[24:20]};
         IMMSRC_CI: begin
            if (rvc) imm = {{58{instr[12]}}, instr[12], instr[6:2]};
            else     err = 1'b1;
         end
         IMMSRC_CJ: begin
            if (rvc) imm = {{52{instr[12]}}, instr[12], instr[8], instr[10:9], instr[6],
                            instr[7], instr[2], instr[11], instr[5:3], 1'b0};
            else     err = 1'b1;
         end
         IMMSRC_CB: begin
            if (rvc) imm = {{55{instr[12]}}, instr[12], instr[6:5], instr[2],
                            instr[11:10], instr[4:3], 1'b0};
            else     err = 1'b1;
         end
         default:      err = 1'b1;
      endcase
      return {err, imm};
   endfunction

endpackage

// File: rtl/immgen_pipe_skid_buf.sv
// Generic two-entry valid/ready buffer: output register plus one skid entry.
// in_ready is a register (skid empty), so out_ready never reaches in_ready combinationally.
module skid_buf #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic         out_valid_q;
   logic [W-1:0] out_data_q;
   logic         skid_valid_q;
   logic [W-1:0] skid_data_q;
   logic         accept;

   assign accept = in_valid && !skid_valid_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
      end else if (!out_valid_q || out_ready) begin
         // Output slot free this cycle: the skid entry has priority to keep order.
         if (skid_valid_q) begin
            out_data_q   <= skid_data_q;
            out_valid_q  <= 1'b1;
            skid_valid_q <= 1'b0;
         end else if (accept) begin
            out_data_q  <= in_data;
            out_valid_q <= 1'b1;
         end else begin
            out_valid_q <= 1'b0;
         end
      end else if (accept) begin
         skid_data_q  <= in_data;
         skid_valid_q <= 1'b1;
      end
   end

   assign in_ready  = !skid_valid_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

endmodule

// File: rtl/immgen_pipe.sv
// Pipelined immediate generator: decode on acceptance, register {err, tag, imm}
// through a skid buffer so results appear one cycle after the accepting edge.
module immgen_pipe
   import immgen_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned RVC   = 0,
   parameter int unsigned TAG_W = 5
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [3:0]       in_immsrc,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_err
);

   localparam int unsigned W = 1 + TAG_W + XLEN;

   logic [64:0]  decoded;
   logic [W-1:0] in_data;
   logic [W-1:0] out_data;
   logic         unused_dec;

   assign decoded    = imm_decode(in_instr, in_immsrc, XLEN == 64, RVC != 0);
   assign in_data    = {decoded[64], in_tag, decoded[XLEN-1:0]};
   // Upper decode bits are dropped when XLEN is 32.
   assign unused_dec = ^decoded;

   skid_buf #(
      .W(W)
   ) u_skid (
      .clk       (clk),
      .resetn    (resetn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   assign {out_err, out_tag, out_imm} = out_data;

endmodule

// File: tb/tb_immgen_pipe.sv
// Scoreboard bench: one RV64/RVC instance and one RV32/no-RVC instance share stimulus;
// each accepted request pushes hand-computed expectations that a monitor pops.
module tb_immgen_pipe;

   typedef struct {
      logic [63:0] imm;
      logic        err;
      logic [4:0]  tag;
   } exp_t;

   localparam int NV = 13;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_instr = '0;
   logic [3:0]  in_immsrc = '0;
   logic [4:0]  in_tag = '0;
   logic        out_ready = 1'b0;
   int          ready_mode = 1;

   logic        a_in_ready, a_out_valid, a_out_err;
   logic [63:0] a_out_imm;
   logic [4:0]  a_out_tag;
   logic        b_in_ready, b_out_valid, b_out_err;
   logic [31:0] b_out_imm;
   logic [4:0]  b_out_tag;

   int checks = 0;
   int errors = 0;

   exp_t qa[$];
   exp_t qb[$];

   logic [31:0] v_instr [NV];
   logic [3:0]  v_src   [NV];
   logic [63:0] v_ea    [NV];
   logic        v_erra  [NV];
   logic [31:0] v_eb    [NV];
   logic        v_errb  [NV];
   logic [4:0]  v_tag   [NV];

   immgen_pipe #(.XLEN(64), .RVC(1), .TAG_W(5)) dut_a (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(a_in_ready),
      .in_instr(in_instr), .in_immsrc(in_immsrc), .in_tag(in_tag),
      .out_valid(a_out_valid), .out_ready(out_ready), .out_imm(a_out_imm),
      .out_tag(a_out_tag), .out_err(a_out_err)
   );

   immgen_pipe #(.XLEN(32), .RVC(0), .TAG_W(5)) dut_b (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(b_in_ready),
      .in_instr(in_instr), .in_immsrc(in_immsrc), .in_tag(in_tag),
      .out_valid(b_out_valid), .out_ready(out_ready), .out_imm(b_out_imm),
      .out_tag(b_out_tag), .out_err(b_out_err)
   );

   initial forever #5 clk = ~clk;

   initial forever begin
      @(negedge clk);
      if (ready_mode == 2) out_ready = 1'($urandom_range(0, 1));
      else                 out_ready = (ready_mode == 1);
   end

   task automatic set_vec(input int i, input logic [31:0] instr, input logic [3:0] src,
                          input logic [63:0] ea, input logic erra,
                          input logic [31:0] eb, input logic errb, input logic [4:0] tag);
      v_instr[i] = instr; v_src[i] = src; v_ea[i] = ea; v_erra[i] = erra;
      v_eb[i] = eb; v_errb[i] = errb; v_tag[i] = tag;
   endtask

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h, want %h", name, got, want);
      end
   endtask

   // Monitor: sampled mid low phase, after the negedge drivers have settled.
   initial forever begin
      exp_t e;
      @(negedge clk);
      #2;
      if (resetn && out_ready && a_out_valid) begin
         checks++;
         if (qa.size() == 0) begin
            errors++;
            $display("FAIL a_unexpected: got imm=%h tag=%0d, want no output", a_out_imm, a_out_tag);
         end else begin
            e = qa.pop_front();
            if (a_out_imm !== e.imm || a_out_err !== e.err || a_out_tag !== e.tag) begin
               errors++;
               $display("FAIL a_result: got imm=%h err=%b tag=%0d, want imm=%h err=%b tag=%0d",
                        a_out_imm, a_out_err, a_out_tag, e.imm, e.err, e.tag);
            end
         end
      end
      if (resetn && out_ready && b_out_valid) begin
         checks++;
         if (qb.size() == 0) begin
            errors++;
            $display("FAIL b_unexpected: got imm=%h tag=%0d, want no output", b_out_imm, b_out_tag);
         end else begin
            e = qb.pop_front();
            if (b_out_imm !== e.imm[31:0] || b_out_err !== e.err || b_out_tag !== e.tag) begin
               errors++;
               $display("FAIL b_result: got imm=%h err=%b tag=%0d, want imm=%h err=%b tag=%0d",
                        b_out_imm, b_out_err, b_out_tag, e.imm[31:0], e.err, e.tag);
            end
         end
      end
   end

   task automatic send(input int k);
      int   n;
      exp_t e;
      n = 0;
      @(negedge clk);
      in_valid  = 1'b1;
      in_instr  = v_instr[k];
      in_immsrc = v_src[k];
      in_tag    = v_tag[k];
      #1;
      while (!a_in_ready && n < 1000) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!a_in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got in_ready=0 for %0d cycles, want acceptance", n);
         in_valid = 1'b0;
      end else begin
         e.imm = v_ea[k]; e.err = v_erra[k]; e.tag = v_tag[k];
         qa.push_back(e);
         e.imm = {32'b0, v_eb[k]}; e.err = v_errb[k];
         qb.push_back(e);
         @(posedge clk);
      end
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((qa.size() != 0 || qb.size() != 0) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      #3;
      chk("drain_a_left", 64'(qa.size()), 64'd0);
      chk("drain_b_left", 64'(qb.size()), 64'd0);
   endtask

   initial begin
      logic [63:0] hold_a;
      logic [31:0] hold_b;
      logic [4:0]  hold_t;

      //        idx instr          src  exp(RV64,RVC)           err  exp(RV32,noRVC) err tag
      set_vec(0,  32'hFFF00093, 4'd0,  64'hFFFFFFFF_FFFFFFFF, 0, 32'hFFFFFFFF, 0, 5'd1);
      set_vec(1,  32'h800002B7, 4'd4,  64'hFFFFFFFF_80000000, 0, 32'h80000000, 0, 5'd2);
      set_vec(2,  32'hFE000EE3, 4'd2,  64'hFFFFFFFF_FFFFFFFC, 0, 32'hFFFFFFFC, 0, 5'd3);
      set_vec(3,  32'h0040006F, 4'd3,  64'h4,                 0, 32'h4,        0, 5'd7);
      set_vec(4,  32'h000F8073, 4'd5,  64'h1F,                0, 32'h1F,       0, 5'd9);
      set_vec(5,  32'h03F00013, 4'd6,  64'h3F,                0, 32'h1F,       0, 5'd10);
      set_vec(6,  32'h0000157D, 4'd7,  64'hFFFFFFFF_FFFFFFFF, 0, 32'h0,        1, 5'd11);
      set_vec(7,  32'h0000BFFD, 4'd8,  64'hFFFFFFFF_FFFFFFFE, 0, 32'h0,        1, 5'd12);
      set_vec(8,  32'h00000004, 4'd9,  64'h20,                0, 32'h0,        1, 5'd13);
      set_vec(9,  32'h00A00423, 4'd1,  64'h8,                 0, 32'h8,        0, 5'd14);
      set_vec(10, 32'hFFFFFFFF, 4'd12, 64'h0,                 1, 32'h0,        1, 5'd15);
      set_vec(11, 32'h07B00093, 4'd0,  64'h7B,                0, 32'h7B,       0, 5'd30);
      set_vec(12, 32'hFFFFFFFF, 4'd10, 64'h0,                 1, 32'h0,        1, 5'd31);

      #23;
      chk("rst_a_out_valid", 64'(a_out_valid), 64'd0);
      chk("rst_a_out_imm",   a_out_imm, 64'd0);
      chk("rst_a_out_tag",   64'(a_out_tag), 64'd0);
      chk("rst_a_in_ready",  64'(a_in_ready), 64'd1);
      chk("rst_b_out_valid", 64'(b_out_valid), 64'd0);
      @(negedge clk);
      resetn = 1'b1;

      // Directed vectors at full throughput.
      for (int i = 0; i < NV; i++) send(i);
      idle();
      drain();

      // Backpressure: two accepts fill both entries, then in_ready must drop.
      ready_mode = 0;
      @(negedge clk);
      send(2);
      send(3);
      @(negedge clk);
      in_valid  = 1'b1;
      in_instr  = v_instr[11];
      in_immsrc = v_src[11];
      in_tag    = v_tag[11];
      #1;
      chk("bp_a_in_ready", 64'(a_in_ready), 64'd0);
      chk("bp_b_in_ready", 64'(b_in_ready), 64'd0);
      chk("bp_a_out_valid", 64'(a_out_valid), 64'd1);
      hold_a = a_out_imm;
      hold_b = b_out_imm;
      hold_t = a_out_tag;
      repeat (3) @(negedge clk);
      #1;
      chk("bp_a_stable_imm", a_out_imm, hold_a);
      chk("bp_b_stable_imm", 64'(b_out_imm), 64'(hold_b));
      chk("bp_a_stable_tag", 64'(a_out_tag), 64'(hold_t));
      chk("bp_a_head_tag", 64'(a_out_tag), 64'd3);
      chk("bp_a_in_ready_held", 64'(a_in_ready), 64'd0);
      ready_mode = 1;
      send(11);
      idle();
      drain();

      // Random valid/ready soak over the directed vector set.
      ready_mode = 2;
      for (int n = 0; n < 10000; n++) begin
         if ($urandom_range(0, 3) == 0) idle();
         send(int'($urandom_range(0, NV - 1)));
      end
      idle();
      ready_mode = 1;
      drain();

      // Asynchronous reset with both entries full.
      ready_mode = 0;
      @(negedge clk);
      send(0);
      send(5);
      idle();
      #1;
      chk("full_a_out_valid", 64'(a_out_valid), 64'd1);
      chk("full_a_in_ready", 64'(a_in_ready), 64'd0);
      @(posedge clk);
      #3;
      resetn = 1'b0;
      #1;
      chk("arst_a_out_valid", 64'(a_out_valid), 64'd0);
      chk("arst_a_out_imm", a_out_imm, 64'd0);
      chk("arst_a_out_tag", 64'(a_out_tag), 64'd0);
      chk("arst_a_out_err", 64'(a_out_err), 64'd0);
      chk("arst_b_out_valid", 64'(b_out_valid), 64'd0);
      chk("arst_b_out_imm", 64'(b_out_imm), 64'd0);
      chk("arst_a_in_ready", 64'(a_in_ready), 64'd1);
      qa.delete();
      qb.delete();
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_in_ready", 64'(a_in_ready), 64'd1);
      chk("post_rst_out_valid", 64'(a_out_valid), 64'd0);
      ready_mode = 1;
      send(3);
      idle();
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
